rxll_frame_reader: RTL and testbench
====================================

RXLL_FRAME_READER -- requirements
Module: rxll_frame_reader

Interface
REQ-001 Parameter C_MAX_WORDS, default 2048, SHALL set the maximum words delivered per frame (legal range 2..65535).
REQ-002 clk  in  1  single clock for all logic; SHALL be the read clock of the upstream RX frame FIFO.
REQ-003 rst_n  in  1  SHALL be a synchronous, active-low reset sampled on the rising edge of clk.
REQ-004 fifo_do  in  36  first-word-fall-through FIFO head: [31:0] data, [32] sof, [33] reserved, [34] eof, [35] link error flag.
REQ-005 fifo_empty  in  1  FIFO head invalid when high.
REQ-006 fifo_eof_rdy  in  1  high while at least one complete frame (eof written) is in the FIFO.
REQ-007 fifo_rd_en  out  1  pops the FIFO head.
REQ-008 ll_data  out  32  LocalLink data, equal to fifo_do[31:0].
REQ-009 ll_sof_n, ll_eof_n, ll_src_rdy_n  out  1 each  active-low LocalLink framing and valid.
REQ-010 ll_dst_rdy_n  in  1  active-low downstream ready.
REQ-011 frame_done  out  1  one-cycle pulse per delivered frame.
REQ-012 frame_len  out  16  word count of last delivered frame.
REQ-013 frame_err  out  1  error status of last delivered frame.
REQ-014 drop_cnt  out  8  saturating count of discarded headless frames.

Function
REQ-015 States SHALL be IDLE, XFER, DROP, DONE; encoding free.
REQ-016 IDLE: when fifo_eof_rdy=1 and fifo_empty=0, SHALL go to XFER if fifo_do[32]=1, else to DROP with headless flag set; no pop in IDLE.
REQ-017 XFER: ll_src_rdy_n SHALL be low iff fifo_empty=0; fifo_rd_en = XFER & !fifo_empty & !ll_dst_rdy_n (a beat); ll_data combinational from fifo_do.
REQ-018 ll_sof_n SHALL be low on the first beat of a frame only (word counter = 0).
REQ-019 16-bit word counter SHALL clear on entry to XFER and increment per beat.
REQ-020 Beat with fifo_do[34]=1: ll_eof_n low, go to DONE.
REQ-021 Beat with counter = C_MAX_WORDS-1 and fifo_do[34]=0: ll_eof_n forced low, error latched, go to DROP (headless flag clear).
REQ-022 Error accumulator SHALL OR in fifo_do[35] of every beat, and set on sof=1 at any beat other than the first.
REQ-023 DROP: fifo_rd_en = !fifo_empty, ll_src_rdy_n high; popped word with eof=1 SHALL go to DONE if headless flag clear, else increment drop_cnt (saturate at 255) and go to IDLE.
REQ-024 DONE: one cycle, frame_done=1, frame_len/frame_err registered from counter/accumulator, then IDLE; frame_len/frame_err SHALL hold until next DONE.
REQ-025 fifo_rd_en SHALL never assert when fifo_empty=1 or outside XFER/DROP.
REQ-026 Stall (ll_dst_rdy_n high) SHALL hold ll_data and flags stable and not pop.
REQ-027 fifo_empty rising mid-frame in XFER SHALL deassert ll_src_rdy_n and wait, no error.

Reset
REQ-028 rst_n=0 SHALL force IDLE, counter 0, fifo_rd_en=0, ll_sof_n=ll_eof_n=ll_src_rdy_n=1, frame_done=0, frame_len=0, frame_err=0, drop_cnt=0, headless/error flags 0, including mid-frame; no FIFO pop during reset.

Verification
REQ-029 3-word frame (sof on w0, eof on w2), dst ready -> 3 beats, sof_n low beat 0, eof_n low beat 2, frame_done pulse, frame_len=3, frame_err=0.
REQ-030 Same frame, ll_dst_rdy_n high 4 cycles mid-frame -> no pops, ll_data stable, frame_len=3.
REQ-031 Headless 2-word frame then valid 1-word frame (sof+eof) -> no ll output for first, drop_cnt=1, second delivered with sof_n and eof_n both low, frame_len=1.
REQ-032 C_MAX_WORDS=4, 6-word frame -> 4 beats, eof_n forced on beat 3, 2 words discarded, frame_len=4, frame_err=1.
REQ-033 Word 1 of 3 carries [35]=1 -> frame_err=1, frame_len=3; rst_n low mid-frame -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/rxll_frame_reader_if.sv
// LocalLink source-side bundle between the RX frame reader and its consumer.
// All LocalLink controls are active-low; ll_data is qualified by ll_src_rdy_n.
interface rxll_frame_reader_if;
  logic [31:0] ll_data;
  logic        ll_sof_n;
  logic        ll_eof_n;
  logic        ll_src_rdy_n;
  logic        ll_dst_rdy_n;

  modport master (
    output ll_data,
    output ll_sof_n,
    output ll_eof_n,
    output ll_src_rdy_n,
    input  ll_dst_rdy_n
  );

  modport slave (
    input  ll_data,
    input  ll_sof_n,
    input  ll_eof_n,
    input  ll_src_rdy_n,
    output ll_dst_rdy_n
  );
endinterface

// File: rtl/rxll_frame_reader.sv
// Drains complete frames from a first-word-fall-through RX FIFO onto a
// LocalLink source port. Frames without a leading sof are discarded and
// counted. Frames longer than C_MAX_WORDS are truncated: eof is forced on the
// last allowed word, the error flag is set and the remainder is discarded.
module rxll_frame_reader #(
  parameter int C_MAX_WORDS = 2048
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [35:0]          fifo_do,
  input  logic                 fifo_empty,
  input  logic                 fifo_eof_rdy,
  output logic                 fifo_rd_en,
  rxll_frame_reader_if.master  ll,
  output logic                 frame_done,
  output logic [15:0]          frame_len,
  output logic                 frame_err,
  output logic [7:0]           drop_cnt
);

  localparam int          SOF_BIT  = 32;
  localparam int          EOF_BIT  = 34;
  localparam int          ERR_BIT  = 35;
  localparam logic [15:0] LAST_IDX = 16'(C_MAX_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_DROP,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] word_cnt, cnt_nxt;
  logic        err_acc, err_nxt;
  logic        headless, headless_nxt;
  logic [7:0]  drop_nxt;
  logic        head_valid;
  logic        beat;

  // Bit 33 of the FIFO word is reserved and intentionally ignored.
  logic unused_rsvd;
  assign unused_rsvd = fifo_do[33];

  // Data passes straight through from the FIFO head; framing qualifies it.
  assign ll.ll_data = fifo_do[31:0];

  // Next-state, bookkeeping and handshake outputs.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = word_cnt;
    err_nxt         = err_acc;
    headless_nxt    = headless;
    drop_nxt        = drop_cnt;
    head_valid      = (state == S_XFER) && !fifo_empty;
    beat            = head_valid && !ll.ll_dst_rdy_n;
    ll.ll_src_rdy_n = !head_valid;
    ll.ll_sof_n     = !(head_valid && (word_cnt == 16'd0));
    ll.ll_eof_n     = !(head_valid && (fifo_do[EOF_BIT] || (word_cnt == LAST_IDX)));
    frame_done      = (state == S_DONE);
    // Reset gates the pop directly so nothing leaves the FIFO while held in reset.
    fifo_rd_en      = rst_n && (beat || ((state == S_DROP) && !fifo_empty));

    unique case (state)
      S_IDLE: begin
        // Only start once a whole frame is buffered, so XFER never waits on eof.
        if (fifo_eof_rdy && !fifo_empty) begin
          if (fifo_do[SOF_BIT]) begin
            state_nxt    = S_XFER;
            cnt_nxt      = 16'd0;
            err_nxt      = 1'b0;
            headless_nxt = 1'b0;
          end else begin
            state_nxt    = S_DROP;
            headless_nxt = 1'b1;
          end
        end
      end
      S_XFER: begin
        if (beat) begin
          cnt_nxt = word_cnt + 16'd1;
          err_nxt = err_acc | fifo_do[ERR_BIT] | (fifo_do[SOF_BIT] && (word_cnt != 16'd0));
          if (fifo_do[EOF_BIT]) begin
            state_nxt = S_DONE;
          end else if (word_cnt == LAST_IDX) begin
            err_nxt      = 1'b1;
            headless_nxt = 1'b0;
            state_nxt    = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (!fifo_empty && fifo_do[EOF_BIT]) begin
          if (headless) begin
            headless_nxt = 1'b0;
            if (drop_cnt != 8'hFF) drop_nxt = drop_cnt + 8'd1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and status registers; results load on entry to DONE so they are
  // already valid while frame_done pulses.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; rst_n is only sampled on the clock edge.
    if (!rst_n) begin
      state     <= S_IDLE;
      word_cnt  <= 16'd0;
      err_acc   <= 1'b0;
      headless  <= 1'b0;
      drop_cnt  <= 8'd0;
      frame_len <= 16'd0;
      frame_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      word_cnt <= cnt_nxt;
      err_acc  <= err_nxt;
      headless <= headless_nxt;
      drop_cnt <= drop_nxt;
      if (state_nxt == S_DONE) begin
        frame_len <= cnt_nxt;
        frame_err <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rxll_frame_reader.sv
// Bench for rxll_frame_reader (C_MAX_WORDS = 4). A queue models the FWFT FIFO;
// expected LocalLink beats and frame results go to scoreboard queues when a
// frame is loaded and are popped as the DUT produces them.
module tb_rxll_frame_reader;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [35:0] fifo_do;
  logic        fifo_empty;
  logic        fifo_eof_rdy;
  logic        fifo_rd_en;
  logic        frame_done;
  logic [15:0] frame_len;
  logic        frame_err;
  logic [7:0]  drop_cnt;

  rxll_frame_reader_if ll ();

  rxll_frame_reader #(.C_MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_do      (fifo_do),
    .fifo_empty   (fifo_empty),
    .fifo_eof_rdy (fifo_eof_rdy),
    .fifo_rd_en   (fifo_rd_en),
    .ll           (ll.master),
    .frame_done   (frame_done),
    .frame_len    (frame_len),
    .frame_err    (frame_err),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sof_n;
    logic        eof_n;
  } beat_t;

  typedef struct {
    logic [15:0] len;
    logic        err;
  } res_t;

  typedef struct {
    int   nwords;
    bit   headless;
    int   err_word;   // -1: none
    int   sof_word;   // extra sof on this word, -1: none
    int   exp_len;
    bit   exp_err;
    int   exp_drop;   // drop_cnt after this frame
  } vec_t;

  logic [35:0] fq[$];
  logic [35:0] last_frame[$];
  beat_t       exp_beat_q[$];
  res_t        exp_res_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit pop_pend = 0;
  bit stall    = 0;
  bit gap      = 0;
  bit rst_drv  = 0;
  int beats_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: got event-missing expected event-seen", name);
  endtask

  task automatic apply_fifo();
    bit any_eof = 0;
    foreach (fq[i]) if (fq[i][34]) any_eof = 1;
    fifo_empty   = (fq.size() == 0) || gap;
    fifo_do      = (fq.size() == 0) ? 36'h0 : fq[0];
    fifo_eof_rdy = any_eof;
  endtask

  // One clock: inputs change at negedge, outputs are sampled 1 time unit later.
  task automatic step();
    logic [35:0] dummy;
    beat_t b;
    res_t  r;
    @(negedge clk);
    if (pop_pend && fq.size() != 0) dummy = fq.pop_front();
    apply_fifo();
    ll.ll_dst_rdy_n = stall;
    rst_n = rst_drv;
    #1;
    if (fifo_rd_en && fifo_empty) begin
      n_checks++;
      $display("FAIL rd_en_on_empty: got 1 expected 0");
    end
    pop_pend = fifo_rd_en;
    if (rst_drv && !ll.ll_src_rdy_n && !ll.ll_dst_rdy_n) begin
      beats_seen++;
      if (exp_beat_q.size() == 0) fail("unexpected_beat");
      else begin
        b = exp_beat_q.pop_front();
        check("beat", {30'd0, ll.ll_sof_n, ll.ll_eof_n, ll.ll_data}, {30'd0, b.sof_n, b.eof_n, b.data});
      end
    end
    if (rst_drv && frame_done) begin
      if (exp_res_q.size() == 0) fail("unexpected_done");
      else begin
        r = exp_res_q.pop_front();
        check("frame_result", {47'd0, frame_len, frame_err}, {47'd0, r.len, r.err});
      end
    end
  endtask

  task automatic load_frame(input int n, input bit headless, input int err_w, input int sof_w,
                            input int exp_len, input bit exp_err);
    logic [35:0] w;
    last_frame.delete();
    for (int i = 0; i < n; i++) begin
      w[31:0] = $urandom;
      w[32]   = (!headless && i == 0) || (i == sof_w);
      w[33]   = 1'b0;
      w[34]   = (i == n - 1);
      w[35]   = (i == err_w);
      fq.push_back(w);
      last_frame.push_back(w);
    end
    if (!headless) begin
      for (int i = 0; i < exp_len; i++)
        exp_beat_q.push_back('{data: last_frame[i][31:0], sof_n: (i != 0), eof_n: (i != exp_len - 1)});
      exp_res_q.push_back('{len: 16'(exp_len), err: exp_err});
    end
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    while ((fq.size() != 0 || pop_pend || exp_beat_q.size() != 0 || exp_res_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) fail({name, "_timeout"});
    step();
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_src_rdy_n"}, ll.ll_src_rdy_n, 1);
    check({tag, "_sof_n"}, ll.ll_sof_n, 1);
    check({tag, "_eof_n"}, ll.ll_eof_n, 1);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_len"}, frame_len, 0);
    check({tag, "_err"}, frame_err, 0);
    check({tag, "_drop"}, drop_cnt, 0);
  endtask

  vec_t vecs[9];

  initial begin
    logic [31:0] held;
    int start;

    vecs[0] = '{3, 0, -1, -1, 3, 0, 0};   // plain 3-word frame
    vecs[1] = '{2, 1, -1, -1, 0, 0, 1};   // headless, dropped
    vecs[2] = '{1, 0, -1, -1, 1, 0, 1};   // single word, sof+eof together
    vecs[3] = '{6, 0, -1, -1, 4, 1, 1};   // oversize: truncated, 2 discarded
    vecs[4] = '{3, 0,  1, -1, 3, 1, 1};   // link error on word 1
    vecs[5] = '{2, 0, -1,  1, 2, 1, 1};   // stray sof on word 1
    vecs[6] = '{4, 0, -1, -1, 4, 0, 1};   // eof exactly on the last allowed word
    vecs[7] = '{5, 0, -1, -1, 4, 1, 1};   // one word over the limit
    vecs[8] = '{1, 1, -1, -1, 0, 0, 2};   // headless single word

    fifo_do = '0; fifo_empty = 1'b1; fifo_eof_rdy = 1'b0;
    ll.ll_dst_rdy_n = 1'b0;
    rst_n = 1'b0;

    // Reset state.
    rst_drv = 0;
    step(); step();
    check_reset_outputs("reset");
    rst_drv = 1;
    step();

    // Table-driven frames.
    foreach (vecs[k]) begin
      load_frame(vecs[k].nwords, vecs[k].headless, vecs[k].err_word, vecs[k].sof_word,
                 vecs[k].exp_len, vecs[k].exp_err);
      run_until_idle($sformatf("vec%0d", k), 200);
      check($sformatf("vec%0d_drop_cnt", k), drop_cnt, vecs[k].exp_drop);
      if (!vecs[k].headless) begin
        check($sformatf("vec%0d_len_hold", k), frame_len, vecs[k].exp_len);
        check($sformatf("vec%0d_err_hold", k), frame_err, vecs[k].exp_err);
      end
    end

    // Downstream stall of 4 cycles after the first beat.
    load_frame(3, 0, -1, -1, 3, 0);
    start = beats_seen;
    for (int i = 0; i < 20 && beats_seen == start; i++) step();
    if (beats_seen == start) fail("stall_first_beat");
    held = last_frame[1][31:0];
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_rd_en", fifo_rd_en, 0);
      check("stall_data", ll.ll_data, held);
      check("stall_flags", {ll.ll_src_rdy_n, ll.ll_sof_n, ll.ll_eof_n}, 3'b011);
    end
    stall = 0;
    run_until_idle("stall", 200);

    // FIFO head goes invalid mid-frame: wait without error.
    load_frame(3, 0, -1, -1, 3, 0);
    start = beats_seen;
    for (int i = 0; i < 20 && beats_seen == start; i++) step();
    if (beats_seen == start) fail("gap_first_beat");
    gap = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("gap_src_rdy_n", ll.ll_src_rdy_n, 1);
      check("gap_rd_en", fifo_rd_en, 0);
    end
    gap = 0;
    run_until_idle("gap", 200);

    // Reset asserted in the middle of a frame.
    load_frame(3, 0, -1, -1, 3, 0);
    start = beats_seen;
    for (int i = 0; i < 20 && beats_seen == start; i++) step();
    if (beats_seen == start) fail("rst_first_beat");
    rst_drv = 0;
    step();
    check("rst_no_pop", fifo_rd_en, 0);
    step();
    check_reset_outputs("midrst");
    fq.delete();
    exp_beat_q.delete();
    exp_res_q.delete();
    pop_pend = 0;
    rst_drv = 1;
    step();

    // drop_cnt saturation.
    for (int i = 0; i < 260; i++) load_frame(1, 1, -1, -1, 0, 0);
    run_until_idle("saturate", 2000);
    check("drop_saturate", drop_cnt, 8'hFF);

    // Recovery: single-word frame after reset and drops.
    load_frame(1, 0, -1, -1, 1, 0);
    run_until_idle("recover", 200);
    check("recover_len", frame_len, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
